// File: rtl/tick_counter_pkg.sv
// tick_counter_pkg: shared types and defaults for the tick_counter block.
// Build option: define TICK_EDGE_EN to count rising edges of tick instead of
// every high cycle.
package tick_counter_pkg;

    // Counter control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tc_state_t;

    // Default counter width.
    localparam int DEFAULT_WIDTH = 8;

endpackage : tick_counter_pkg

// File: rtl/tick_counter_tick_qualify.sv
// tick_qualify: turns the raw tick input into the count enable.
// Build option TICK_EDGE_EN: when defined, only a rising edge of tick qualifies
// (tick high while last cycle's tick was low); the edge is decoded from the
// live input so it adds no latency. When undefined, every high cycle
// qualifies and no history register exists.
module tick_qualify (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    output logic qual
);

`ifdef TICK_EDGE_EN
    logic tick_prev;

    // Remember last cycle's tick level for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_prev <= 1'b0;
        end else begin
            tick_prev <= tick;
        end
    end

    assign qual = tick & ~tick_prev;
`else
    // Level mode has no state; clock and reset are intentionally unused here.
    logic unused_level_mode;
    assign unused_level_mode = clk ^ reset;

    assign qual = tick;
`endif

endmodule : tick_qualify

// File: rtl/tick_counter.sv
// tick_counter: programmable modulo up/down counter fed by the divide-by-3
// enable stream. IDLE/RUN/DONE control FSM, parallel load with clamp to max,
// synchronous clear, free-running or one-shot wrap.
// Build option TICK_EDGE_EN selects edge-qualified ticks (see tick_qualify).
//
// Priority, highest first: reset > clear > load > tick.
// count and tc are flops; running/done/dbg_state decode the state flop only,
// so no input reaches an output combinationally.
module tick_counter
    import tick_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             clear,
    input  logic             one_shot,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             running,
    output logic             done,
    output tc_state_t        dbg_state
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    tc_state_t        state_q;
    tc_state_t        state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             qual_tick;
    logic             count_en;
    logic             wrap;

    tick_qualify u_qualify (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .qual  (qual_tick)
    );

    // A tick only advances the counter in RUN and only if load/clear are idle.
    assign count_en = (state_q == RUN) && qual_tick && !clear && !load;

    // Wrap condition for the current direction; max may change between ticks.
    assign wrap = dir ? (count_q >= max) : (count_q == ZERO);

    // Counter datapath: next count and terminal-count pulse.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clear) begin
            count_d = ZERO;
        end else if (load) begin
            count_d = (load_val > max) ? max : load_val;
        end else if (count_en) begin
            tc_d = wrap;
            if (dir) begin
                count_d = wrap ? ZERO : count_q + ONE;
            end else begin
                count_d = wrap ? max : count_q - ONE;
            end
        end
    end

    // Count and tc registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= ZERO;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; clear overrides everything including start.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (count_en && wrap && one_shot) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM output decode, driven from the state flop only.
    always_comb begin
        running   = (state_q == RUN);
        done      = (state_q == DONE);
        dbg_state = state_q;
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule : tick_counter

// File: tb/tb_tick_counter.sv
// tb_tick_counter: directed scenarios plus randomized traffic for
// tick_counter, checked against a cycle-level behavioural model.
// Honours TICK_EDGE_EN the same way as the design build.
module tb_tick_counter;
    import tick_counter_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         tick;
    logic         start;
    logic         clear;
    logic         one_shot;
    logic         dir;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] max;
    logic [W-1:0] count;
    logic         tc;
    logic         running;
    logic         done;
    tc_state_t    dbg_state;

    int n_checks;
    int n_errors;

    // Behavioural model: mode 0 idle, 1 counting, 2 finished.
    int m_mode;
    int m_count;
    int m_tc;
    int m_prev_tick;

    tick_counter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .clear     (clear),
        .one_shot  (one_shot),
        .dir       (dir),
        .load      (load),
        .load_val  (load_val),
        .max       (max),
        .count     (count),
        .tc        (tc),
        .running   (running),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model advanced once per rising edge from the sampled inputs.
    task automatic model_edge();
        int qual;
        int modulus;
        if (!reset) begin
            m_mode      = 0;
            m_count     = 0;
            m_tc        = 0;
            m_prev_tick = 0;
            return;
        end
`ifdef TICK_EDGE_EN
        qual = (tick && m_prev_tick == 0) ? 1 : 0;
`else
        qual = tick ? 1 : 0;
`endif
        m_prev_tick = tick ? 1 : 0;
        modulus = int'(max) + 1;
        m_tc = 0;
        if (clear) begin
            m_count = 0;
            m_mode  = 0;
        end else begin
            if (load) begin
                m_count = (int'(load_val) > int'(max)) ? int'(max) : int'(load_val);
            end else if (m_mode == 1 && qual == 1) begin
                if (dir) begin
                    if (m_count >= int'(max)) begin
                        m_count = 0;
                        m_tc = 1;
                    end else begin
                        m_count = m_count + 1;
                    end
                end else begin
                    if (m_count == 0) begin
                        m_count = modulus - 1;
                        m_tc = 1;
                    end else begin
                        m_count = m_count - 1;
                    end
                end
                if (m_tc == 1 && one_shot) m_mode = 2;
            end
            if (m_mode == 0 && start) m_mode = 1;
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        tick = 0; start = 0; clear = 0; load = 0;
    endtask

    task automatic test_reset();
        reset = 0; one_shot = 0; dir = 1; load_val = '0; max = 8'd4;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            start = i[0]; tick = ~i[0];
            step();
            n_checks++;
            if (count !== 8'd0 || tc !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL reset cyc%0d: count=%0d tc=%b run=%b done=%b, want all 0",
                         i, count, tc, running, done);
            end
        end
        idle_inputs();
        reset = 1;
        step();
    endtask

    task automatic test_div3_freerun();
        int ph;
        int last_tc;
        int n_tc;
        max = 8'd4; dir = 1; one_shot = 0;
        start = 1;
        step();
        start = 0;
        n_checks++;
        if (running !== 1'b1 || count !== 8'd0) begin
            n_errors++;
            $display("FAIL div3_start: running=%b count=%0d, want 1 0", running, count);
        end
        ph = 0; last_tc = -1; n_tc = 0;
        for (int c = 0; c < 48; c++) begin
            tick = (ph == 2);
            ph = (ph + 1) % 3;
            step();
            n_checks++;
            if (count !== W'(m_count) || tc !== m_tc[0]) begin
                n_errors++;
                $display("FAIL div3 cyc%0d: count=%0d tc=%b, want %0d %0d",
                         c, count, tc, m_count, m_tc);
            end
            if (tc === 1'b1) begin
                if (last_tc >= 0) begin
                    n_checks++;
                    if (c - last_tc != 15) begin
                        n_errors++;
                        $display("FAIL div3_tc_period: got %0d, want 15", c - last_tc);
                    end
                end
                last_tc = c;
                n_tc++;
            end
        end
        tick = 0;
        n_checks++;
        if (n_tc != 3) begin
            n_errors++;
            $display("FAIL div3_tc_count: got %0d, want 3", n_tc);
        end
    endtask

    task automatic test_down_oneshot();
        idle_inputs();
        clear = 1;
        step();
        clear = 0; max = 8'd2; dir = 0; one_shot = 1; start = 1;
        step();
        start = 0; tick = 1;
        step();
        tick = 0;
        n_checks++;
        if (count !== 8'd2 || tc !== 1'b1 || done !== 1'b1 || running !== 1'b0) begin
            n_errors++;
            $display("FAIL down_wrap: count=%0d tc=%b done=%b run=%b, want 2 1 1 0",
                     count, tc, done, running);
        end
        for (int i = 0; i < 6; i++) begin
            tick = i[0];
            step();
            n_checks++;
            if (count !== 8'd2 || tc !== 1'b0 || done !== 1'b1) begin
                n_errors++;
                $display("FAIL down_hold cyc%0d: count=%0d tc=%b done=%b, want 2 0 1",
                         i, count, tc, done);
            end
        end
        tick = 0;
    endtask

    task automatic test_load_tick();
        idle_inputs();
        clear = 1;
        step();
        clear = 0; dir = 1; one_shot = 0; max = 8'd5; start = 1;
        step();
        start = 0; tick = 0;
        step();
        load = 1; load_val = 8'd9; tick = 1;
        step();
        load = 0; tick = 0;
        n_checks++;
        if (count !== 8'd5 || tc !== 1'b0) begin
            n_errors++;
            $display("FAIL load_clamp: count=%0d tc=%b, want 5 0", count, tc);
        end
        step();
        tick = 1;
        step();
        tick = 0;
        n_checks++;
        if (count !== 8'd0 || tc !== 1'b1) begin
            n_errors++;
            $display("FAIL load_then_wrap: count=%0d tc=%b, want 0 1", count, tc);
        end
    endtask

    task automatic test_clear_load();
        idle_inputs();
        max = 8'd10; dir = 1; one_shot = 0;
        clear = 1;
        step();
        clear = 0; start = 1;
        step();
        start = 0; load = 1; load_val = 8'd3;
        step();
        n_checks++;
        if (count !== 8'd3 || running !== 1'b1) begin
            n_errors++;
            $display("FAIL load_in_run: count=%0d run=%b, want 3 1", count, running);
        end
        clear = 1; load = 1; load_val = 8'd7; tick = 1;
        step();
        idle_inputs();
        n_checks++;
        if (count !== 8'd0 || running !== 1'b0 || done !== 1'b0 || tc !== 1'b0
            || dbg_state !== IDLE) begin
            n_errors++;
            $display("FAIL clear_load: count=%0d run=%b done=%b tc=%b st=%0d, want 0 0 0 0 IDLE",
                     count, running, done, tc, dbg_state);
        end
    endtask

    task automatic test_held_tick();
        int expect_inc;
`ifdef TICK_EDGE_EN
        expect_inc = 1;
`else
        expect_inc = 6;
`endif
        idle_inputs();
        max = 8'd255; dir = 1; one_shot = 0;
        clear = 1;
        step();
        clear = 0; start = 1;
        step();
        start = 0; load = 1; load_val = 8'd20;
        step();
        load = 0;
        for (int i = 0; i < 6; i++) begin
            tick = 1;
            step();
        end
        tick = 0;
        step();
        n_checks++;
        if (count !== W'(20 + expect_inc)) begin
            n_errors++;
            $display("FAIL held_tick: count=%0d, want %0d", count, 20 + expect_inc);
        end
    endtask

    task automatic test_max_zero();
        idle_inputs();
        max = 8'd0; dir = 1; one_shot = 0;
        clear = 1;
        step();
        clear = 0; start = 1;
        step();
        start = 0;
        for (int i = 0; i < 8; i++) begin
            tick = i[0];
            step();
            n_checks++;
            if (count !== 8'd0 || tc !== i[0]) begin
                n_errors++;
                $display("FAIL max_zero cyc%0d: count=%0d tc=%b, want 0 %b",
                         i, count, tc, i[0]);
            end
        end
        tick = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 99) != 0);
            clear    = ($urandom_range(0, 39) == 0);
            start    = ($urandom_range(0, 7) == 0);
            load     = ($urandom_range(0, 15) == 0);
            tick     = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 31) == 0) dir = ~dir;
            if ($urandom_range(0, 31) == 0) one_shot = ~one_shot;
            if ($urandom_range(0, 49) == 0)
                max = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 7));
            load_val = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 9));
            step();
            n_checks++;
            if (count !== W'(m_count) || tc !== m_tc[0] ||
                running !== (m_mode == 1) || done !== (m_mode == 2)) begin
                n_errors++;
                $display("FAIL random cyc%0d: count=%0d tc=%b run=%b done=%b, want %0d %0d %0d %0d",
                         c, count, tc, running, done, m_count, m_tc,
                         (m_mode == 1), (m_mode == 2));
            end
        end
        reset = 1;
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_mode = 0; m_count = 0; m_tc = 0; m_prev_tick = 0;
        test_reset();
        test_div3_freerun();
        test_down_oneshot();
        test_load_tick();
        test_clear_load();
        test_held_tick();
        test_max_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_tick_counter
